// File: rtl/mcl86_bus_pkg.sv
// Shared types and constants for the mcl86 bus bridges.
package mcl86_bus_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    localparam int                TIMEOUT_DEF   = 255;
    localparam logic [DATA_W-1:0] IDLE_DATA_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } bus_state_e;

endpackage

// File: rtl/mcl86_bus_wdt.sv
// Loadable watchdog down-counter; expire strobes while enabled at zero.
module mcl86_bus_wdt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    // Count down from the loaded value; clear beats load beats decrement.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/mcl86_bus_bridge.sv
// 8088 local-bus to req/ack system-bus bridge with watchdog and INTA handling.
module mcl86_bus_bridge
    import mcl86_bus_pkg::*;
#(
    parameter int                TIMEOUT   = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] IDLE_DATA = IDLE_DATA_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_ale_i,
    input  logic              cpu_rd_n_i,
    input  logic              cpu_wr_n_i,
    input  logic              cpu_iom_i,
    input  logic              cpu_inta_n_i,
    input  logic [ADDR_W-1:0] cpu_ad_i,
    output logic [DATA_W-1:0] cpu_ad_o,
    output logic              cpu_ready_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic              bus_io_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic [DATA_W-1:0] vec_i,
    output logic              intack_o,
    output logic              timeout_o
);

    localparam int WDT_W = $clog2(TIMEOUT + 1);

    bus_state_e state, next_state;
    logic       inta_cnt;
    logic       cmd;
    logic       inta_take;
    logic       req_enter;
    logic       wdt_expire;
    logic       timeout_fire;

    assign cmd          = !cpu_rd_n_i || !cpu_wr_n_i;
    // DONE is excluded so a held INTA_n low does not count as a new pulse.
    assign inta_take    = (state != DONE) && !cpu_inta_n_i;
    assign req_enter    = (state != REQ) && (next_state == REQ);
    // An ack in the expiry cycle wins over the watchdog.
    assign timeout_fire = (state == REQ) && cpu_inta_n_i && !bus_ack_i && wdt_expire;

    mcl86_bus_wdt #(.W(WDT_W)) u_wdt (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (next_state != REQ),
        .load     (req_enter),
        .load_val (WDT_W'(TIMEOUT - 1)),
        .en       (state == REQ),
        .expire   (wdt_expire)
    );

    // Next-state decode; INTA pre-empts any command or pending request.
    always_comb begin
        // NOTE: next_state gets a default first so no path leaves it unassigned and infers a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (inta_take)      next_state = DONE;
                else if (cmd)       next_state = REQ;
                else if (cpu_ale_i) next_state = ADDR;
            end
            ADDR: begin
                if (inta_take) next_state = DONE;
                else if (cmd)  next_state = REQ;
            end
            REQ: begin
                if (inta_take)                    next_state = DONE;
                else if (bus_ack_i || wdt_expire) next_state = DONE;
            end
            DONE: begin
                if (cpu_rd_n_i && cpu_wr_n_i && cpu_inta_n_i) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State, address/data latches, read-data return and INTA pulse counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            inta_cnt    <= 1'b0;
            cpu_ad_o    <= '0;
            bus_we_o    <= 1'b0;
            bus_io_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            intack_o    <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state     <= next_state;
            intack_o  <= 1'b0;
            timeout_o <= timeout_fire;

            if (((state == IDLE) || (state == ADDR)) && cpu_ale_i) begin
                bus_addr_o <= cpu_ad_i;
                bus_io_o   <= cpu_iom_i;
            end

            if (req_enter) begin
                bus_we_o    <= !cpu_wr_n_i;
                bus_wdata_o <= cpu_ad_i[DATA_W-1:0];
            end

            if ((state == REQ) && cpu_inta_n_i && !bus_we_o) begin
                if (bus_ack_i)       cpu_ad_o <= bus_rdata_i;
                else if (wdt_expire) cpu_ad_o <= IDLE_DATA;
            end

            if (inta_take) begin
                inta_cnt <= !inta_cnt;
                if (inta_cnt) begin
                    cpu_ad_o <= vec_i;
                    intack_o <= 1'b1;
                end else begin
                    cpu_ad_o <= IDLE_DATA;
                end
            end
        end
    end

    assign cpu_ready_o = (state == DONE);
    assign bus_req_o   = (state == REQ);

endmodule

// File: tb/tb_mcl86_bus_bridge.sv
// Self-checking bench for mcl86_bus_bridge: vector table, INTA/reset sequences, random accesses.
module tb_mcl86_bus_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ale, rd_n, wr_n, iom, inta_n;
    logic [19:0] ad;
    logic [7:0]  cpu_ad;
    logic        ready, req, we, io;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [7:0]  rdata, vec;
    logic        intack, tmo;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference-model state: what the bridge should currently hold.
    logic [19:0] m_addr;
    logic        m_io;
    logic [7:0]  m_ad;

    typedef struct {
        logic        use_ale;
        logic        rd;
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wdata;
        int          ack_dly;
        logic [7:0]  rdata;
        logic        exp_we;
        logic        exp_io;
        logic [19:0] exp_addr;
        int          exp_cycles;
        logic        exp_to;
        logic [7:0]  exp_ad;
    } vec_t;

    vec_t tbl [8];

    mcl86_bus_bridge #(.TIMEOUT(TO), .IDLE_DATA(8'hFF)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_ale_i    (ale),
        .cpu_rd_n_i   (rd_n),
        .cpu_wr_n_i   (wr_n),
        .cpu_iom_i    (iom),
        .cpu_inta_n_i (inta_n),
        .cpu_ad_i     (ad),
        .cpu_ad_o     (cpu_ad),
        .cpu_ready_o  (ready),
        .bus_req_o    (req),
        .bus_we_o     (we),
        .bus_io_o     (io),
        .bus_addr_o   (addr),
        .bus_wdata_o  (wdata),
        .bus_ack_i    (ack),
        .bus_rdata_i  (rdata),
        .vec_i        (vec),
        .intack_o     (intack),
        .timeout_o    (tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req"},    32'(req),    32'd0);
        check({tag, " we"},     32'(we),     32'd0);
        check({tag, " io"},     32'(io),     32'd0);
        check({tag, " addr"},   32'(addr),   32'd0);
        check({tag, " wdata"},  32'(wdata),  32'd0);
        check({tag, " ready"},  32'(ready),  32'd0);
        check({tag, " cpu_ad"}, 32'(cpu_ad), 32'd0);
        check({tag, " intack"}, 32'(intack), 32'd0);
        check({tag, " tmo"},    32'(tmo),    32'd0);
    endtask

    // Expected outcome of one access from the bridge's rules, at transaction level.
    function automatic vec_t build(input logic use_ale, input logic rd, input logic wr,
                                   input logic io_s, input logic [19:0] a, input logic [7:0] wd,
                                   input int dly, input logic [7:0] rd_data);
        vec_t v;
        v.use_ale    = use_ale;
        v.rd         = rd;
        v.wr         = wr;
        v.io         = io_s;
        v.addr       = a;
        v.wdata      = wd;
        v.ack_dly    = dly;
        v.rdata      = rd_data;
        v.exp_we     = wr;
        v.exp_io     = use_ale ? io_s : m_io;
        v.exp_addr   = use_ale ? a : m_addr;
        v.exp_to     = (dly >= TO);
        v.exp_cycles = v.exp_to ? TO : dly + 1;
        v.exp_ad     = v.exp_we ? m_ad : (v.exp_to ? 8'hFF : rd_data);
        return v;
    endfunction

    task automatic commit(input vec_t v);
        m_addr = v.exp_addr;
        m_io   = v.exp_io;
        m_ad   = v.exp_ad;
    endtask

    // Drive one CPU bus cycle and act as the system-bus target.
    task automatic do_access(input vec_t v, input string tag);
        int n;
        if (v.use_ale) begin
            ale = 1'b1;
            ad  = v.addr;
            iom = v.io;
            tick();
            ale = 1'b0;
        end
        ad   = {v.addr[19:8], v.wdata};
        rd_n = !v.rd;
        wr_n = !v.wr;
        tick();
        n = 0;
        while (req && (n < 40)) begin
            n++;
            check({tag, " addr"},  32'(addr),  32'(v.exp_addr));
            check({tag, " we"},    32'(we),    32'(v.exp_we));
            check({tag, " io"},    32'(io),    32'(v.exp_io));
            check({tag, " ready"}, 32'(ready), 32'd0);
            if (v.exp_we) check({tag, " wdata"}, 32'(wdata), 32'(v.wdata));
            if (n == v.ack_dly + 1) begin
                ack   = 1'b1;
                rdata = v.rdata;
            end
            tick();
            ack   = 1'b0;
            rdata = 8'($urandom);
        end
        check({tag, " req cycles"}, 32'(n),      32'(v.exp_cycles));
        check({tag, " timeout"},    32'(tmo),    32'(v.exp_to));
        check({tag, " done ready"}, 32'(ready),  32'd1);
        check({tag, " cpu_ad"},     32'(cpu_ad), 32'(v.exp_ad));
        tick();
        check({tag, " timeout one pulse"}, 32'(tmo),   32'd0);
        check({tag, " ready held"},        32'(ready), 32'd1);
        rd_n = 1'b1;
        wr_n = 1'b1;
        tick();
        check({tag, " ready after release"}, 32'(ready), 32'd0);
        check({tag, " req after release"},   32'(req),   32'd0);
        commit(v);
    endtask

    initial begin
        vec_t v;
        logic [7:0] keep_ad;
        rst = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom = 1'b0; inta_n = 1'b1;
        ad = '0; ack = 1'b0; rdata = '0; vec = '0;
        m_addr = '0; m_io = 1'b0; m_ad = 8'h00;

        // use_ale rd wr io addr wdata dly rdata | we io addr cycles to ad
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'hFFFF0, 8'h00,   2, 8'hEA, 1'b0, 1'b0, 20'hFFFF0,  3, 1'b0, 8'hEA};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 20'h00060, 8'h5A,   0, 8'h11, 1'b1, 1'b1, 20'h00060,  1, 1'b0, 8'hEA};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 8'h00, 255, 8'h33, 1'b0, 1'b0, 20'h12345, 16, 1'b1, 8'hFF};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'h12345, 8'h00,  15, 8'h3C, 1'b0, 1'b0, 20'h12345, 16, 1'b0, 8'h3C};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 20'hABCDE, 8'hC3, 255, 8'h00, 1'b1, 1'b0, 20'hABCDE, 16, 1'b1, 8'h3C};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 20'h55555, 8'h00,  14, 8'h05, 1'b0, 1'b0, 20'hABCDE, 15, 1'b0, 8'h05};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 20'h0FF00, 8'h77,   1, 8'h99, 1'b1, 1'b1, 20'h0FF00,  2, 1'b0, 8'h05};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 20'h00061, 8'h00,   0, 8'hA5, 1'b0, 1'b1, 20'h00061,  1, 1'b0, 8'hA5};

        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_access(tbl[i], $sformatf("vec%0d", i));

        // An ack outside REQ must not move the bridge or its read data.
        ack = 1'b1; rdata = 8'h5E;
        tick();
        ack = 1'b0;
        check("stray ack req",    32'(req),    32'd0);
        check("stray ack ready",  32'(ready),  32'd0);
        check("stray ack cpu_ad", 32'(cpu_ad), 32'(m_ad));

        // INTA pair: first pulse idle data, second the vector with intack.
        vec = 8'h08;
        inta_n = 1'b0;
        tick();
        check("inta1 ready",  32'(ready),  32'd1);
        check("inta1 cpu_ad", 32'(cpu_ad), 32'hFF);
        check("inta1 intack", 32'(intack), 32'd0);
        check("inta1 req",    32'(req),    32'd0);
        tick();
        check("inta1 held ready", 32'(ready), 32'd1);
        check("inta1 held req",   32'(req),   32'd0);
        inta_n = 1'b1;
        tick();
        check("inta1 exit ready", 32'(ready), 32'd0);
        ale = 1'b1; ad = m_addr; iom = m_io;
        tick();
        ale = 1'b0; inta_n = 1'b0;
        tick();
        check("inta2 ready",  32'(ready),  32'd1);
        check("inta2 cpu_ad", 32'(cpu_ad), 32'h08);
        check("inta2 intack", 32'(intack), 32'd1);
        check("inta2 req",    32'(req),    32'd0);
        tick();
        check("inta2 intack pulse", 32'(intack), 32'd0);
        inta_n = 1'b1;
        tick();
        check("inta2 exit ready", 32'(ready), 32'd0);
        // Counter back at zero: the next pair starts again with idle data.
        vec = 8'h21;
        inta_n = 1'b0;
        tick();
        check("inta3 cpu_ad", 32'(cpu_ad), 32'hFF);
        check("inta3 intack", 32'(intack), 32'd0);
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        check("inta4 cpu_ad", 32'(cpu_ad), 32'h21);
        check("inta4 intack", 32'(intack), 32'd1);
        inta_n = 1'b1;
        tick();
        m_ad = 8'h21;

        // Random accesses against the transaction-level model.
        for (int i = 0; i < 30; i++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            v = build(($urandom_range(0, 4) != 0), (kind != 2), (kind >= 2),
                      1'($urandom), 20'($urandom), 8'($urandom),
                      int'($urandom_range(0, 20)), 8'($urandom));
            do_access(v, $sformatf("rnd%0d", i));
        end

        // Reset two cycles into a request, then a fresh read.
        keep_ad = m_ad;
        ale = 1'b1; ad = 20'h2468A; iom = 1'b1;
        tick();
        ale = 1'b0; rd_n = 1'b0;
        tick();
        check("pre-reset req", 32'(req), 32'd1);
        tick();
        check("pre-reset cpu_ad", 32'(cpu_ad), 32'(keep_ad));
        rst = 1'b1;
        tick();
        check_reset_outputs("mid reset");
        rst = 1'b0; rd_n = 1'b1;
        m_addr = '0; m_io = 1'b0; m_ad = 8'h00;
        tick();
        v = build(1'b1, 1'b1, 1'b0, 1'b1, 20'h13579, 8'h00, 3, 8'h6B);
        do_access(v, "post-reset read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
